video_text_writer: RTL and testbench

Character-stream front end for the text-mode video path. It accepts bytes over a valid/ready handshake, tracks a cursor on the 107×40 character grid, and interprets a small set of control codes. It issues single-cell writes (address, character code, write enable) directly into the `video_mem` write port, so the scan-out side only ever sees finished glyph codes. It sits between the host byte source (UART/keyboard/CPU port) and `video_mem`.

---
 rtl/video_text_writer.sv | 162 ++++++++++++++++
 tb/tb_video_text_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/video_text_writer.sv
// Byte-stream text writer: cursor tracking, control codes, and clear sequencing into video_mem.
// Optional build macro TW_ROW_CLEAR_EN blanks each new row on a row advance.
module video_text_writer #(
  parameter int CH_WIDTH_SCREEN  = 107,
  parameter int CH_HEIGHT_SCREEN = 40,
  parameter int ADDR_W           = 13
) (
  input  logic              write_clk,
  input  logic              rst_n,
  input  logic [7:0]        tw_data,
  input  logic              tw_valid,
  output logic              tw_ready,
  output logic [ADDR_W-1:0] vm_ch_addr,
  output logic [7:0]        vm_ch_out,
  output logic              vm_ch_write_enable,
  output logic [6:0]        tw_cur_col,
  output logic [5:0]        tw_cur_row,
  output logic              tw_busy
);

  localparam logic [7:0] CODE_CR    = 8'h0D;
  localparam logic [7:0] CODE_LF    = 8'h0A;
  localparam logic [7:0] CODE_BS    = 8'h08;
  localparam logic [7:0] CODE_FF    = 8'h0C;
  localparam logic [7:0] CODE_SPACE = 8'h20;

  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(CH_WIDTH_SCREEN);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CH_WIDTH_SCREEN * CH_HEIGHT_SCREEN - 1);
  localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(CH_WIDTH_SCREEN - 1);
  localparam logic [6:0]        LAST_COL   = 7'(CH_WIDTH_SCREEN - 1);
  localparam logic [5:0]        LAST_ROW   = 6'(CH_HEIGHT_SCREEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_SCR = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [6:0]        col_reg;
  logic [5:0]        row_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        out_reg;
  logic              we_reg;

  logic              accept;
  logic              is_glyph;
  logic              row_adv;
  logic              row_wrap;
  logic [5:0]        row_adv_val;
  logic [ADDR_W-1:0] base_adv_val;

  assign accept   = tw_valid && (state_reg == IDLE);
  assign is_glyph = (tw_data != CODE_CR) && (tw_data != CODE_LF) &&
                    (tw_data != CODE_BS) && (tw_data != CODE_FF);
  assign row_adv  = accept && ((tw_data == CODE_LF) || (is_glyph && (col_reg == LAST_COL)));

  // The row base tracks row*width incrementally so no multiplier is needed.
  assign row_wrap     = (row_reg == LAST_ROW);
  assign row_adv_val  = row_wrap ? 6'd0 : row_reg + 6'd1;
  assign base_adv_val = row_wrap ? '0 : base_reg + ROW_STEP;

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && (tw_data == CODE_FF)) state_next = CLR_SCR;
`ifdef TW_ROW_CLEAR_EN
        else if (row_adv)                   state_next = CLR_ROW;
`endif
      end
      CLR_SCR: if (clr_cnt_reg == LAST_CELL) state_next = IDLE;
`ifdef TW_ROW_CLEAR_EN
      CLR_ROW: if (clr_cnt_reg == LAST_COL_A) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tw_ready = (state_reg == IDLE);
    tw_busy  = (state_reg != IDLE);
  end

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg     <= '0;
      row_reg     <= '0;
      base_reg    <= '0;
      clr_cnt_reg <= '0;
      addr_reg    <= '0;
      out_reg     <= '0;
      we_reg      <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            clr_cnt_reg <= '0;
            if (row_adv) begin
              row_reg  <= row_adv_val;
              base_reg <= base_adv_val;
            end
            case (tw_data)
              CODE_CR, CODE_LF: col_reg <= '0;
              CODE_BS: begin
                if (col_reg != 7'd0) begin
                  col_reg  <= col_reg - 7'd1;
                  addr_reg <= base_reg + ADDR_W'(col_reg - 7'd1);
                  out_reg  <= CODE_SPACE;
                  we_reg   <= 1'b1;
                end
              end
              CODE_FF: ;
              default: begin
                addr_reg <= base_reg + ADDR_W'(col_reg);
                out_reg  <= tw_data;
                we_reg   <= 1'b1;
                col_reg  <= (col_reg == LAST_COL) ? 7'd0 : col_reg + 7'd1;
              end
            endcase
          end
        end
        CLR_SCR: begin
          addr_reg    <= clr_cnt_reg;
          out_reg     <= CODE_SPACE;
          we_reg      <= 1'b1;
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          // Cursor homes only once the last cell has been issued.
          if (clr_cnt_reg == LAST_CELL) begin
            col_reg  <= '0;
            row_reg  <= '0;
            base_reg <= '0;
          end
        end
`ifdef TW_ROW_CLEAR_EN
        CLR_ROW: begin
          addr_reg    <= base_reg + clr_cnt_reg;
          out_reg     <= CODE_SPACE;
          we_reg      <= 1'b1;
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign vm_ch_addr         = addr_reg;
  assign vm_ch_out          = out_reg;
  assign vm_ch_write_enable = we_reg;
  assign tw_cur_col         = col_reg;
  assign tw_cur_row         = row_reg;

endmodule

// File: tb/tb_video_text_writer.sv
// Self-checking bench for video_text_writer against a cell-level reference model of the text grid.
// Expectations follow TW_ROW_CLEAR_EN when the bundle is built with it.
module tb_video_text_writer;
  localparam int W  = 107;
  localparam int H  = 40;
  localparam int AW = 13;

  logic          write_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic [7:0]    tw_data   = 8'h00;
  logic          tw_valid  = 1'b0;
  logic          tw_ready;
  logic [AW-1:0] vm_ch_addr;
  logic [7:0]    vm_ch_out;
  logic          vm_ch_write_enable;
  logic [6:0]    tw_cur_col;
  logic [5:0]    tw_cur_row;
  logic          tw_busy;

  video_text_writer #(.CH_WIDTH_SCREEN(W), .CH_HEIGHT_SCREEN(H), .ADDR_W(AW)) dut (
    .write_clk(write_clk), .rst_n(rst_n), .tw_data(tw_data), .tw_valid(tw_valid),
    .tw_ready(tw_ready), .vm_ch_addr(vm_ch_addr), .vm_ch_out(vm_ch_out),
    .vm_ch_write_enable(vm_ch_write_enable), .tw_cur_col(tw_cur_col),
    .tw_cur_row(tw_cur_row), .tw_busy(tw_busy)
  );

  always #5 write_clk = ~write_clk;

  int cyc = 0;
  always @(posedge write_clk) cyc <= cyc + 1;

  typedef struct { int c; int a; int d; } wr_t;
  wr_t obs[$];
  wr_t exp_q[$];

  always @(negedge write_clk)
    if (vm_ch_write_enable === 1'b1) obs.push_back('{cyc, int'(vm_ch_addr), int'(vm_ch_out)});

  int tests = 0;
  int fails = 0;
  int mcol  = 0;
  int mrow  = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push_wr(input int c, input int a, input int d);
    exp_q.push_back('{c, a, d});
  endtask

  task automatic model_advance(input int e);
    mrow = (mrow + 1) % H;
`ifdef TW_ROW_CLEAR_EN
    for (int k = 0; k < W; k++) push_wr(e + 1 + k, mrow * W + k, 32);
`endif
  endtask

  task automatic model_apply(input logic [7:0] b, input int e);
    case (b)
      8'h0D: mcol = 0;
      8'h0A: begin mcol = 0; model_advance(e); end
      8'h08: if (mcol > 0) begin mcol--; push_wr(e, mrow * W + mcol, 32); end
      8'h0C: begin
        for (int k = 0; k < W * H; k++) push_wr(e + 1 + k, k, 32);
        mcol = 0; mrow = 0;
      end
      default: begin
        push_wr(e, mrow * W + mcol, int'(b));
        if (mcol == W - 1) begin mcol = 0; model_advance(e); end
        else mcol++;
      end
    endcase
  endtask

  // Presents one byte from a falling edge and holds it until the rising edge that takes it.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge write_clk);
    tw_data  = b;
    tw_valid = 1'b1;
    while (tw_ready !== 1'b1) begin
      @(negedge write_clk);
      n++;
      if (n > 10000) begin
        chk("ready_timeout", 0, 1);
        tw_valid = 1'b0;
        return;
      end
    end
    @(posedge write_clk);
    #1;
    tw_valid = 1'b0;
    model_apply(b, cyc);
  endtask

  task automatic check_writes(input string tag);
    int n = 0;
    int m;
    while (tw_ready !== 1'b1 && n < 10000) begin @(negedge write_clk); n++; end
    if (n >= 10000) chk({tag, "_idle_timeout"}, 0, 1);
    repeat (3) @(negedge write_clk);
    chk({tag, "_wr_count"}, obs.size(), exp_q.size());
    m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk({tag, "_wr{cyc,addr,data}"}, {obs[i].c, obs[i].a[15:0], obs[i].d[7:0]},
          {exp_q[i].c, exp_q[i].a[15:0], exp_q[i].d[7:0]});
    obs.delete();
    exp_q.delete();
    chk({tag, "_col"}, tw_cur_col, mcol);
    chk({tag, "_row"}, tw_cur_row, mrow);
    $display("[TB] step %s done, %0d writes checked", tag, m);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, n_low, n_busy, rc;
    logic [7:0] b;
    wr_t keep[$];

    repeat (3) @(posedge write_clk);
    @(negedge write_clk);
    rst_n = 1'b1;
    #1;
    chk("rst_addr", vm_ch_addr, 0);
    chk("rst_out", vm_ch_out, 0);
    chk("rst_we", vm_ch_write_enable, 0);
    chk("rst_busy", tw_busy, 0);
    chk("rst_ready", tw_ready, 1);
    chk("rst_col", tw_cur_col, 0);
    chk("rst_row", tw_cur_row, 0);

    send(8'h41);
    send(8'h42);
    check_writes("ab");

    send(8'h0D);
    for (int i = 0; i < W; i++) send(8'h58);
    check_writes("right_edge");

    send(8'h0D);
    send(8'h08);
    check_writes("bs_col0");
    send(8'h51);
    send(8'h08);
    check_writes("q_bs");

    for (int blk = 0; blk < 5; blk++) begin
      for (int i = 0; i < 50; i++) begin
        int r = $urandom_range(0, 99);
        if      (r < 6)  b = 8'h0A;
        else if (r < 12) b = 8'h0D;
        else if (r < 22) b = 8'h08;
        else begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h0C) b = 8'h41;
        end
        send(b);
      end
      check_writes("random");
    end

    send(8'h0C);
    n_low  = 0;
    n_busy = 0;
    @(negedge write_clk);
    while (tw_ready !== 1'b1 && n_low < 6000) begin
      n_low++;
      if (tw_busy === 1'b1) n_busy++;
      @(negedge write_clk);
    end
    chk("ff_ready_low_cycles", n_low, W * H);
    chk("ff_busy_cycles", n_busy, W * H);
    check_writes("ff");

    for (int i = 0; i < H; i++) begin
      send(8'h0A);
      chk("lf_row", tw_cur_row, mrow);
    end
    chk("lf_wrapped_row", mrow, 0);
    check_writes("vwrap");

    send(8'h5A);
    send(8'h0C);
    e0 = cyc;
    while (cyc < e0 + 2000) begin @(posedge write_clk); #2; end
    rst_n = 1'b0;
    rc = cyc;
    #1;
    chk("midclr_we_drop", vm_ch_write_enable, 0);
    chk("midclr_busy_drop", tw_busy, 0);
    foreach (exp_q[i]) if (exp_q[i].c < rc) keep.push_back(exp_q[i]);
    exp_q = keep;
    mcol = 0;
    mrow = 0;
    repeat (3) @(posedge write_clk);
    @(negedge write_clk);
    rst_n = 1'b1;
    repeat (20) @(negedge write_clk);
    chk("midclr_ready", tw_ready, 1);
    chk("midclr_busy", tw_busy, 0);
    check_writes("midclr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
